regfile_multiport: RTL and testbench

//  Parametrised multi-port register file for the pipelined CPU: NUM_RD combinational read ports,
//  two write ports (W0 = ALU writeback, W1 = memory writeback) and a per-register pending scoreboard
//  for hazard detection. Register ZERO_REG is hard-wired to 0. Sits between decode and writeback.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_entry.sv | 39 +++
 rtl/regfile_multiport.sv | 85 ++++++++
 tb/tb_regfile_multiport.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the CPU register file: default geometry, the
//   hard-wired zero register index and the address/data typedefs used by
//   code that talks to the register file at its default size.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_entry.sv
// regfile_entry
//   One architectural register plus its pending (scoreboard) bit.
//   Ports:
//     clk, reset  - clock, synchronous active-high reset (clears data and pending)
//     wr_en       - store wr_data this cycle; also clears pending
//     wr_data     - data to store (collision priority already resolved by the caller)
//     rsv_en      - mark this register pending; beats a same-cycle write clear
//     data, pend  - current register contents and pending bit
module regfile_entry #(
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    output logic [DATA_W-1:0] data,
    output logic              pend
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            pend <= 1'b0;
        end else begin
            if (wr_en) begin
                data <= wr_data;
            end
            // A reservation in the same cycle as a write means a new producer
            // was issued after the one now retiring, so the register stays pending.
            if (rsv_en) begin
                pend <= 1'b1;
            end else if (wr_en) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport
//   Multi-port register file with pending scoreboard for the pipelined CPU.
//   NUM_RD combinational read ports, two write ports (wr0 = ALU writeback,
//   wr1 = memory writeback; wr1 wins on an address collision) and a
//   reservation port that marks a register pending until it is written.
//   Register ZERO_REG always reads 0 and is never pending.
//   Ports:
//     clk, reset                    - clock, synchronous active-high reset
//     rd_addr[p] -> rd_data[p], rd_pend[p] - combinational read ports
//     wr0_en/wr0_addr/wr0_data      - write port 0
//     wr1_en/wr1_addr/wr1_data      - write port 1 (priority)
//     rsv_en/rsv_addr               - reserve (set pending)
//   Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
//   to matching read ports; otherwise reads return stored state only.
module regfile_multiport #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]              rd_pend,
    input  logic                           wr0_en,
    input  logic [ADDR_W-1:0]              wr0_addr,
    input  logic [DATA_W-1:0]              wr0_data,
    input  logic                           wr1_en,
    input  logic [ADDR_W-1:0]              wr1_addr,
    input  logic [DATA_W-1:0]              wr1_data,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_addr
);
    import regfile_pkg::*;

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] rf_q   [DEPTH];
    logic              pend_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign rf_q[i]   = '0;
            assign pend_q[i] = 1'b0;
        end else begin : g_ent
            logic hit0, hit1, hit_rsv;
            assign hit0    = wr0_en && (wr0_addr == ADDR_W'(i));
            assign hit1    = wr1_en && (wr1_addr == ADDR_W'(i));
            assign hit_rsv = rsv_en && (rsv_addr == ADDR_W'(i));

            regfile_entry #(.DATA_W(DATA_W)) u_entry (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (hit0 || hit1),
                .wr_data (hit1 ? wr1_data : wr0_data),
                .rsv_en  (hit_rsv),
                .data    (rf_q[i]),
                .pend    (pend_q[i])
            );
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = rf_q[rd_addr[p]];
            rd_pend[p] = pend_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            // Forward the value being written this cycle. The forwarded
            // register is about to be un-pended unless it is re-reserved now.
            if (!reset && (rd_addr[p] != ZERO_ADDR)) begin
                if (wr1_en && (wr1_addr == rd_addr[p])) begin
                    rd_data[p] = wr1_data;
                    rd_pend[p] = rsv_en && (rsv_addr == rd_addr[p]);
                end else if (wr0_en && (wr0_addr == rd_addr[p])) begin
                    rd_data[p] = wr0_data;
                    rd_pend[p] = rsv_en && (rsv_addr == rd_addr[p]);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport
//   Directed self-checking bench for regfile_multiport (default parameters,
//   two read ports). Follows REGFILE_BYPASS_EN for the bypass expectations.
module tb_regfile_multiport;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                          clk;
    logic                          reset;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_pend;
    logic                          wr0_en;
    logic [ADDR_W-1:0]             wr0_addr;
    logic [DATA_W-1:0]             wr0_data;
    logic                          wr1_en;
    logic [ADDR_W-1:0]             wr1_addr;
    logic [DATA_W-1:0]             wr1_data;
    logic                          rsv_en;
    logic [ADDR_W-1:0]             rsv_addr;

    int total;
    int bad;

    regfile_multiport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(31)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_pend  (rd_pend),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
    endtask

    // Reads happen with all enables low, so the state is stable across edges.
    task automatic read_port(input int p, input logic [ADDR_W-1:0] a,
                             output logic [DATA_W-1:0] d, output logic pd);
        rd_addr[p] = a;
        #1;
        d  = rd_data[p];
        pd = rd_pend[p];
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d;
        logic pd;
        reset = 1'b1;
        idle();
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            read_port(0, a[ADDR_W-1:0], d, pd);
            total++;
            if (d !== '0 || pd !== 1'b0) begin
                bad++;
                $display("FAIL reset_init addr=%0d data=%h pend=%b required data=0 pend=0", a, d, pd);
            end
        end
        // Fill X0..X30 with nonzero data and reserve each one.
        for (int a = 0; a < 31; a++) begin
            wr0_en = 1'b1; wr0_addr = a[ADDR_W-1:0];
            wr0_data = 64'hC0DE_0000_0000_0000 | 64'(a + 1);
            rsv_en = 1'b1; rsv_addr = a[ADDR_W-1:0];
            tick();
        end
        idle();
        read_port(1, 5'd12, d, pd);
        total++;
        if (d !== 64'hC0DE_0000_0000_000D || pd !== 1'b1) begin
            bad++;
            $display("FAIL fill_x12 data=%h pend=%b required data=c0de00000000000d pend=1", d, pd);
        end
        // Reset for one cycle with a write and a reservation also requested.
        reset = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 64'h1234;
        wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 64'h5678;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        reset = 1'b0;
        idle();
        for (int a = 0; a < 32; a++) begin
            for (int p = 0; p < NUM_RD; p++) begin
                read_port(p, a[ADDR_W-1:0], d, pd);
                total++;
                if (d !== '0 || pd !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_clear port=%0d addr=%0d data=%h pend=%b required data=0 pend=0", p, a, d, pd);
                end
            end
        end
    endtask

    task automatic test_basic_rw();
        logic [DATA_W-1:0] d;
        logic pd;
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        idle();
        read_port(0, 5'd5, d, pd);
        total++;
        if (d !== 64'hDEAD_BEEF_0000_0001 || pd !== 1'b0) begin
            bad++;
            $display("FAIL basic_x5 data=%h pend=%b required data=deadbeef00000001 pend=0", d, pd);
        end
        read_port(1, 5'd6, d, pd);
        total++;
        if (d !== '0) begin
            bad++;
            $display("FAIL basic_x6 data=%h required 0", d);
        end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] d;
        logic pd;
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'h22;
        tick();
        idle();
        for (int p = 0; p < NUM_RD; p++) begin
            read_port(p, 5'd7, d, pd);
            total++;
            if (d !== 64'h22) begin
                bad++;
                $display("FAIL collision port=%0d data=%h required 22", p, d);
            end
        end
        // Different addresses on both ports in one cycle: both land.
        wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 64'h1313;
        wr1_en = 1'b1; wr1_addr = 5'd14; wr1_data = 64'h1414;
        tick();
        idle();
        read_port(0, 5'd13, d, pd);
        total++;
        if (d !== 64'h1313) begin
            bad++;
            $display("FAIL dual_write_x13 data=%h required 1313", d);
        end
        read_port(1, 5'd14, d, pd);
        total++;
        if (d !== 64'h1414) begin
            bad++;
            $display("FAIL dual_write_x14 data=%h required 1414", d);
        end
    endtask

    task automatic test_zero_reg();
        logic [DATA_W-1:0] d;
        logic pd;
        wr1_en = 1'b1; wr1_addr = 5'd31; wr1_data = '1;
        wr0_en = 1'b1; wr0_addr = 5'd31; wr0_data = 64'h77;
        rsv_en = 1'b1; rsv_addr = 5'd31;
        tick();
        idle();
        for (int p = 0; p < NUM_RD; p++) begin
            read_port(p, 5'd31, d, pd);
            total++;
            if (d !== '0 || pd !== 1'b0) begin
                bad++;
                $display("FAIL zero_reg port=%0d data=%h pend=%b required data=0 pend=0", p, d, pd);
            end
        end
        // X30 sits next to the zero register and must stay untouched.
        read_port(0, 5'd30, d, pd);
        total++;
        if (d !== '0 || pd !== 1'b0) begin
            bad++;
            $display("FAIL zero_neighbour_x30 data=%h pend=%b required data=0 pend=0", d, pd);
        end
    endtask

    task automatic test_scoreboard();
        logic [DATA_W-1:0] d;
        logic pd;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        read_port(1, 5'd9, d, pd);
        total++;
        if (pd !== 1'b1 || d !== '0) begin
            bad++;
            $display("FAIL sb_reserve pend=%b data=%h required pend=1 data=0", pd, d);
        end
        read_port(0, 5'd10, d, pd);
        total++;
        if (pd !== 1'b0) begin
            bad++;
            $display("FAIL sb_other_x10 pend=%b required 0", pd);
        end
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h5;
        tick();
        idle();
        read_port(0, 5'd9, d, pd);
        total++;
        if (pd !== 1'b0 || d !== 64'h5) begin
            bad++;
            $display("FAIL sb_write_clear pend=%b data=%h required pend=0 data=5", pd, d);
        end
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'h99;
        tick();
        idle();
        read_port(0, 5'd9, d, pd);
        total++;
        if (pd !== 1'b1 || d !== 64'h99) begin
            bad++;
            $display("FAIL sb_set_wins pend=%b data=%h required pend=1 data=99", pd, d);
        end
        // A write on port 1 alone also clears pending.
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'hAB;
        tick();
        idle();
        read_port(1, 5'd9, d, pd);
        total++;
        if (pd !== 1'b0 || d !== 64'hAB) begin
            bad++;
            $display("FAIL sb_wr1_clear pend=%b data=%h required pend=0 data=ab", pd, d);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_same;
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h77;
        tick();
        idle();
        rd_addr[0] = 5'd3;
        rd_addr[1] = 5'd3;
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'hA5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 64'hA5;
`else
        exp_same = 64'h77;
`endif
        for (int p = 0; p < NUM_RD; p++) begin
            total++;
            if (rd_data[p] !== exp_same) begin
                bad++;
                $display("FAIL bypass_same_cycle port=%0d data=%h required %h", p, rd_data[p], exp_same);
            end
        end
        tick();
        idle();
        #1;
        total++;
        if (rd_data[0] !== 64'hA5) begin
            bad++;
            $display("FAIL bypass_next_cycle data=%h required a5", rd_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d;
        logic pd;
        for (int a = 16; a < 20; a++) begin
            wr0_en = 1'b1; wr0_addr = a[ADDR_W-1:0]; wr0_data = 64'(a * 3);
            wr1_en = 1'b1; wr1_addr = 5'(a + 4);     wr1_data = 64'(a * 5);
            tick();
        end
        idle();
        for (int a = 16; a < 20; a++) begin
            read_port(0, a[ADDR_W-1:0], d, pd);
            total++;
            if (d !== 64'(a * 3)) begin
                bad++;
                $display("FAIL b2b_wr0 addr=%0d data=%h required %h", a, d, 64'(a * 3));
            end
            read_port(1, 5'(a + 4), d, pd);
            total++;
            if (d !== 64'(a * 5)) begin
                bad++;
                $display("FAIL b2b_wr1 addr=%0d data=%h required %h", a + 4, d, 64'(a * 5));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        rd_addr = '0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        test_reset();
        test_basic_rw();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
